// File: rtl/menu_input_pkg.sv
// Shared constants for the Pong pause-menu control path.
// Cursor encodings are also used by main_fsm and the menu renderers.
package menu_input_pkg;

    localparam logic MENU_CONTINUE = 1'b0;
    localparam logic MENU_RESTART  = 1'b1;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef struct packed {
        logic level;
        logic rise;
    } chan_t;

endpackage

// File: rtl/menu_input_if.sv
// Joystick/menu bundle between the board pins, menu_input and main_fsm.
// master drives raw contacts and menu_active; slave is menu_input.
interface menu_input_if;

    logic button_raw;
    logic up_raw;
    logic down_raw;
    logic menu_active;
    logic enter;
    logic enter_pulse;
    logic value;

    modport master (
        output button_raw, up_raw, down_raw, menu_active,
        input  enter, enter_pulse, value
    );

    modport slave (
        input  button_raw, up_raw, down_raw, menu_active,
        output enter, enter_pulse, value
    );

endinterface

// File: rtl/menu_input_debouncer.sv
// One joystick contact: 2-flop synchroniser, stability counter,
// debounced level and a registered rising-edge flag.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_st;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_accept;

    // Enough consecutive disagreeing samples to accept the new level
    assign w_accept = (r_s2 != r_st) && (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_st   <= 1'b0;
            r_rise <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_rise <= w_accept & r_s2;
            if (r_s2 == r_st) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_st  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_st;
    assign rise  = r_rise;

endmodule

// File: rtl/menu_input.sv
// Joystick front-end: debounced enter level/pulse and the
// Continue/Restart cursor sampled by main_fsm in PAUSE.
module menu_input
    import menu_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    menu_input_if.slave   bus
);

    chan_t w_btn;
    chan_t w_up;
    chan_t w_dn;
    logic  r_menu_d;
    logic  r_value;
    logic  w_value_nxt;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock (clock),
        .reset (reset),
        .raw   (bus.button_raw),
        .level (w_btn.level),
        .rise  (w_btn.rise)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clock (clock),
        .reset (reset),
        .raw   (bus.up_raw),
        .level (w_up.level),
        .rise  (w_up.rise)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clock (clock),
        .reset (reset),
        .raw   (bus.down_raw),
        .level (w_dn.level),
        .rise  (w_dn.rise)
    );

    // Selection is frozen while enter is held so main_fsm sees a stable choice
    always_comb begin
        w_value_nxt = r_value;
        if (!bus.menu_active || !r_menu_d) begin
            w_value_nxt = MENU_CONTINUE;
        end else if (w_btn.level) begin
            w_value_nxt = r_value;
        end else if (w_up.rise && w_dn.rise) begin
            w_value_nxt = r_value;
        end else if (w_dn.rise) begin
            w_value_nxt = MENU_RESTART;
        end else if (w_up.rise) begin
            w_value_nxt = MENU_CONTINUE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_menu_d <= 1'b0;
            r_value  <= MENU_CONTINUE;
        end else begin
            r_menu_d <= bus.menu_active;
            r_value  <= w_value_nxt;
        end
    end

    assign bus.enter       = w_btn.level;
    assign bus.enter_pulse = w_btn.rise;
    assign bus.value       = r_value;

endmodule

// File: tb/tb_menu_input.sv
// Directed bench for menu_input with a behavioural reference model
// checked every cycle plus literal timing expectations.
module tb_menu_input;

    localparam int N = 16;

    logic clock;
    logic reset;

    int n_checks;
    int n_errors;

    menu_input_if bus ();

    menu_input #(.DEBOUNCE_CYCLES(N)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model state: 0 = button, 1 = up, 2 = down
    logic m_st   [3];
    logic m_rise [3];
    int   m_run  [3];
    logic m_pipe [3][$];
    logic m_val;
    logic m_menu_d;

    task automatic check(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0b expected %0b at %0t", nm, got, exp, $time);
        end
    endtask

    // Raw samples reach the debounce logic two edges late; a level is
    // accepted after N consecutive late samples disagree with it.
    task automatic model_edge();
        logic raw [3];
        logic nv;
        logic d;
        raw[0] = bus.button_raw;
        raw[1] = bus.up_raw;
        raw[2] = bus.down_raw;
        if (!reset) begin
            for (int c = 0; c < 3; c++) begin
                m_st[c]   = 1'b0;
                m_rise[c] = 1'b0;
                m_run[c]  = 0;
                m_pipe[c] = '{1'b0, 1'b0};
            end
            m_val    = 1'b0;
            m_menu_d = 1'b0;
        end else begin
            nv = m_val;
            if (!bus.menu_active)           nv = 1'b0;
            else if (!m_menu_d)             nv = 1'b0;
            else if (m_st[0])               nv = m_val;
            else if (m_rise[1] && m_rise[2]) nv = m_val;
            else if (m_rise[2])             nv = 1'b1;
            else if (m_rise[1])             nv = 1'b0;
            m_val    = nv;
            m_menu_d = bus.menu_active;
            for (int c = 0; c < 3; c++) begin
                d = m_pipe[c].pop_front();
                m_pipe[c].push_back(raw[c]);
                m_rise[c] = 1'b0;
                if (d !== m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == N) begin
                        m_st[c]   = d;
                        m_rise[c] = d;
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("model_enter", bus.enter, m_st[0]);
        check("model_pulse", bus.enter_pulse, m_rise[0]);
        check("model_value", bus.value, m_val);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_up();
        bus.up_raw = 1'b1;
        steps(20);
        bus.up_raw = 1'b0;
        steps(20);
    endtask

    task automatic press_down();
        bus.down_raw = 1'b1;
        steps(20);
        bus.down_raw = 1'b0;
        steps(20);
    endtask

    int pulses;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int c = 0; c < 3; c++) m_pipe[c] = '{1'b0, 1'b0};
        reset           = 1'b0;
        bus.button_raw  = 1'b1;
        bus.up_raw      = 1'b1;
        bus.down_raw    = 1'b1;
        bus.menu_active = 1'b0;

        // reset held with all contacts pressed
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_enter", bus.enter, 1'b0);
            check("rst_pulse", bus.enter_pulse, 1'b0);
            check("rst_value", bus.value, 1'b0);
        end
        reset = 1'b1;
        steps(17);
        check("rel_enter_early", bus.enter, 1'b0);
        step();
        check("rel_enter_edge17", bus.enter, 1'b1);
        check("rel_pulse", bus.enter_pulse, 1'b1);
        step();
        check("rel_pulse_width", bus.enter_pulse, 1'b0);
        bus.button_raw = 1'b0;
        bus.up_raw     = 1'b0;
        bus.down_raw   = 1'b0;
        steps(20);

        // bouncing button, then steady press
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            bus.button_raw = ((i / 3) % 2) == 0;
            step();
            check("bounce_enter", bus.enter, 1'b0);
        end
        bus.button_raw = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            if (bus.enter_pulse) pulses++;
        end
        check("bounce_enter_early", bus.enter, 1'b0);
        step();
        if (bus.enter_pulse) pulses++;
        check("bounce_enter_edge17", bus.enter, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.enter_pulse) pulses++;
        end
        bus.button_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.enter_pulse) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL bounce_pulse_count got %0d expected 1", pulses);
        end

        // cursor navigation
        bus.menu_active = 1'b1;
        steps(2);
        press_down();
        check("cur_down", bus.value, 1'b1);
        press_down();
        check("cur_down_sat", bus.value, 1'b1);
        press_up();
        check("cur_up", bus.value, 1'b0);
        press_down();
        check("cur_down2", bus.value, 1'b1);
        bus.menu_active = 1'b0;
        step();
        check("cur_menu_drop", bus.value, 1'b0);

        // frozen selection while enter is held
        bus.menu_active = 1'b1;
        steps(2);
        press_down();
        check("frz_pre", bus.value, 1'b1);
        bus.button_raw = 1'b1;
        steps(20);
        check("frz_enter", bus.enter, 1'b1);
        press_up();
        check("frz_held", bus.value, 1'b1);
        bus.button_raw = 1'b0;
        steps(20);
        check("frz_released", bus.value, 1'b1);
        press_up();
        check("frz_up_after", bus.value, 1'b0);

        // up and down together
        bus.up_raw   = 1'b1;
        bus.down_raw = 1'b1;
        steps(20);
        check("conf_v0", bus.value, 1'b0);
        bus.up_raw   = 1'b0;
        bus.down_raw = 1'b0;
        steps(20);
        press_down();
        bus.up_raw   = 1'b1;
        bus.down_raw = 1'b1;
        steps(20);
        check("conf_v1", bus.value, 1'b1);
        bus.up_raw   = 1'b0;
        bus.down_raw = 1'b0;
        steps(20);
        press_up();

        // press accepted alongside down: rise lands while enter is high
        bus.button_raw = 1'b1;
        bus.down_raw   = 1'b1;
        steps(20);
        check("same_edge_hold", bus.value, 1'b0);
        bus.button_raw = 1'b0;
        bus.down_raw   = 1'b0;
        steps(20);
        check("same_edge_after", bus.value, 1'b0);

        // reset during debounce restarts it
        bus.button_raw = 1'b1;
        steps(10);
        reset = 1'b0;
        step();
        check("mid_rst_value", bus.value, 1'b0);
        reset = 1'b1;
        steps(17);
        check("mid_enter_early", bus.enter, 1'b0);
        step();
        check("mid_enter_edge17", bus.enter, 1'b1);
        steps(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/menu_input.md
# menu_input

Joystick front-end for the Pong control path. It synchronises and debounces the raw joystick button and up/down switches. It drives a clean `enter` level and a single-cycle `enter_pulse` into `main_fsm`, and keeps the pause-menu cursor `value` (Continue/Restart) that `main_fsm` samples together with `enter` while in PAUSE.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required to accept a change. Must be ≥ 2. Counter width is clog2(DEBOUNCE_CYCLES).
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low.
- `button_raw`  in  1  joystick push switch, active-high, asynchronous to `clock`, bouncy.
- `up_raw`  in  1  joystick up contact, active-high, asynchronous.
- `down_raw`  in  1  joystick down contact, active-high, asynchronous.
- `menu_active`  in  1  from `main_fsm.enable_pause`; high while the pause menu is shown.
- `enter`  out  1  debounced button level, feeds `main_fsm.enter`.
- `enter_pulse`  out  1  one-cycle pulse on a debounced button press.
- `value`  out  1  cursor: 0 = Continue, 1 = Restart; feeds `main_fsm.value`.

## Operation
- Per input channel:
  - A 2-flop synchroniser (`s1`, `s2`).
  - A debounce counter `cnt` and a stable register `st`.
  - If `s2 == st`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `st` ← `s2` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- Rising-edge flag `rise` is registered. It is 1 exactly in the cycle after the edge where `st` goes 0→1, which is the same cycle `st` first reads 1.
- `enter` = button `st`. `enter_pulse` = button `rise`.
- Cursor register `value` is updated each edge. Priority, highest first:
  1. `menu_active == 0` → 0.
  2. `menu_active` was 0 last cycle (entry into the menu) → 0.
  3. `enter == 1` → hold. The selection is frozen while the button is held, so `main_fsm` samples a stable choice.
  4. `up_rise & down_rise` → hold.
  5. `down_rise` → 1.
  6. `up_rise` → 0.
  7. Otherwise → hold.
- Repeated `down_rise` while `value` is already 1 keeps it at 1. There is no wrap-around.
- Reset (`reset == 0` at a posedge) clears all of the following, regardless of in-flight debouncing:
  - All `s1`/`s2`, `cnt`, `st` and `rise` registers.
  - The stored previous value of `menu_active`.
  - `value`.
- Output values during and right after reset: `enter` = 0, `enter_pulse` = 0, `value` = 0. A button held through reset is re-debounced from 0 after release of reset.

## Timing
- Latency: a raw level first sampled at edge 0 and held steady gives `s2` after edge 1. The corresponding `st`/`enter` change is visible after edge `DEBOUNCE_CYCLES`+1, which is edge 17 at default.
- Glitches: any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles resets `cnt` and never changes `st`.
- `enter_pulse` width is exactly 1 cycle per accepted press. No pulse is produced on release. No second pulse occurs until a debounced release followed by a new debounced press.
- `value` changes on the edge after the corresponding `rise` cycle, i.e. one cycle after `st` of up/down goes high.
- `main_fsm` sees `enter` and `value` from the same edge. A press accepted in the same cycle as a `down_rise` leaves `value` at its pre-press state, because `rise` lands while `enter` is already 1.
- Simultaneous changes on different channels are independent. The cursor priority above resolves conflicts.

## Structure
- Shared constants header/package:
  - `MENU_CONTINUE` = 1'b0, `MENU_RESTART` = 1'b1, used by `main_fsm` and the menu renderers.
  - `DEBOUNCE_CYCLES_DEFAULT` = 16.
- One sub-module `input_debouncer`:
  - Contains the synchroniser, counter, stable register and rise flag.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clock`, `reset`, `raw`, `level`, `rise`.
  - Instanced three times: button, up, down.
- Top level holds only the cursor register and the `menu_active` delay flop.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with all raw inputs = 1 → `enter` = 0, `enter_pulse` = 0, `value` = 0 throughout. After release, `enter` rises 17 edges after the first post-reset sample.
- Bounce: `button_raw` toggles every 3 cycles for 40 cycles, then holds 1 (DEBOUNCE_CYCLES = 16) → `enter` stays 0 during bounce. It goes 1 exactly 17 edges after the final steady 1. Exactly one `enter_pulse` is produced.
- Cursor: `menu_active` 0→1, then debounced `down` press → `value` = 1. Debounced `up` → `value` = 0. Second `down` → 1. Drop `menu_active` → `value` = 0 the next edge.
- Frozen selection: `menu_active` = 1 with `value` = 1. Hold button (`enter` = 1), then press `up` → `value` stays 1 until `enter` returns to 0. A later `up` sets it to 0.
- Conflict: `up_raw` and `down_raw` rise on the same edge and are held, with `value` = 0 → `value` stays 0.
- Reset mid-debounce: `button_raw` = 1 for 10 cycles, then `reset` = 0 for 1 cycle, input still 1 → `enter` rises 17 edges after reset release, not earlier.
